// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between decode/EX and the mul/div engine.
// The master side issues operations and MTHI/MTLO; the slave owns HI/LO.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_signed, opa, opb,
    output cancel, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, opa, opb,
    input  cancel, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// Works on magnitudes; signs are restored in a single FIX cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ah_q, ah_d;
  logic [WIDTH-1:0] al_q, al_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic div_q, div_d;
  logic neg_q, neg_d;
  logic rneg_q, rneg_d;
  logic dz_q, dz_d;
  logic done_q, done_d;

  logic             sa, sb;
  logic [WIDTH-1:0] ma, mb;
  logic [WIDTH:0]   sum, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    sa    = bus.op_signed & bus.opa[WIDTH-1];
    sb    = bus.op_signed & bus.opb[WIDTH-1];
    ma    = sa ? -bus.opa : bus.opa;
    mb    = sb ? -bus.opb : bus.opb;
    sum   = {1'b0, ah_q} + (al_q[0] ? {1'b0, b_q} : '0);
    trial = {ah_q, al_q[WIDTH-1]} - {1'b0, b_q};
    prod  = neg_q ? -{ah_q, al_q} : {ah_q, al_q};
    // Zero divisor gives all-ones quotient regardless of signs
    quo   = dz_q ? '1 : (neg_q ? -al_q : al_q);
    rem   = rneg_q ? -ah_q : ah_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ah_d    = ah_q;
    al_d    = al_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start && !bus.cancel) begin
          state_d = CALC;
          cnt_d   = CW'(WIDTH - 1);
          ah_d    = '0;
          al_d    = bus.op_div ? ma : mb;
          b_d     = bus.op_div ? mb : ma;
          div_d   = bus.op_div;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
          dz_d    = bus.op_div && (bus.opb == '0);
        end
      end
      CALC: begin
        if (bus.cancel) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            if (!trial[WIDTH]) begin
              ah_d = trial[WIDTH-1:0];
              al_d = {al_q[WIDTH-2:0], 1'b1};
            end else begin
              ah_d = {ah_q[WIDTH-2:0], al_q[WIDTH-1]};
              al_d = {al_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            ah_d = sum[WIDTH:1];
            al_d = {sum[0], al_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ah_q    <= '0;
      al_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ah_q    <= ah_d;
      al_q    <= al_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: arithmetic reference model,
// monitor pops expected HI/LO and done cycle on every done pulse.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t         sb_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [63:0]  pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_op(bit dv, bit sg,
                                         logic [W-1:0] a,
                                         logic [W-1:0] b);
    longint      qa, qb;
    logic [63:0] p;
    if (!dv) begin
      if (sg) p = longint'($signed(a)) * longint'($signed(b));
      else    p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (sg) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
      return {32'(qa % qb), 32'(qa / qb)};
    end
    return {a % b, a / b};
  endfunction

  // Monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("done_hi", bus.hi, e.hi);
        chk("done_lo", bus.lo, e.lo);
        chk("done_latency", W'(cyc), W'(e.due));
      end
    end
  end

  task automatic issue(bit dv, bit sg, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    bus.start     = 1'b1;
    bus.op_div    = dv;
    bus.op_signed = sg;
    bus.opa       = a;
    bus.opb       = b;
    pend  = ref_op(dv, sg, a, b);
    e.hi  = pend[63:32];
    e.lo  = pend[31:0];
    e.due = cyc + W + 2;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", W'(bus.busy), W'(1));
  endtask

  task automatic finish_op();
    int n = 0;
    while (!bus.done && n < W + 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 10);
      sb_q.delete();
    end else begin
      m_hi = pend[63:32];
      m_lo = pend[31:0];
      chk("busy_at_done", W'(bus.busy), W'(0));
    end
    @(negedge clk);
    chk("hold_hi", bus.hi, m_hi);
    chk("hold_lo", bus.lo, m_lo);
  endtask

  task automatic op(bit dv, bit sg, logic [W-1:0] a, logic [W-1:0] b);
    issue(dv, sg, a, b);
    finish_op();
  endtask

  initial begin
    bus.start = 0; bus.op_div = 0; bus.op_signed = 0;
    bus.opa = '0; bus.opb = '0; bus.cancel = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = '0;
    #1;
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_hi", bus.hi, '0);
    chk("rst_lo", bus.lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(0, 1, 32'hFFFF_FFFD, 32'd7);
    op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(1, 1, 32'hFFFF_FFF9, 32'd2);
    op(1, 0, 32'hFFFF_FFF9, 32'd2);
    op(1, 1, 32'h0000_1234, 32'd0);
    op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
    op(1, 1, 32'h8000_0005, 32'd0);

    for (int i = 0; i < 40; i++) begin
      bit dv, sg;
      logic [W-1:0] a, b;
      dv = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 100);
        default: ;
      endcase
      op(dv, sg, a, b);
    end

    // MTHI/MTLO in idle
    bus.hi_we = 1; bus.lo_we = 1; bus.wdata = 32'h1357_9BDF;
    @(negedge clk);
    bus.hi_we = 0; bus.lo_we = 0;
    m_hi = 32'h1357_9BDF; m_lo = 32'h1357_9BDF;
    chk("mthi_idle", bus.hi, m_hi);
    chk("mtlo_idle", bus.lo, m_lo);

    // Ignored second start, ignored MTHI while busy, then cancel
    issue(0, 1, 32'h1111_1111, 32'h2222_2222);
    repeat (2) @(negedge clk);
    bus.hi_we = 1; bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 0;
    @(negedge clk);
    bus.start = 1; bus.opa = 32'd3; bus.opb = 32'd4;
    @(negedge clk);
    bus.start = 0;
    repeat (4) @(negedge clk);
    chk("busy_mid", W'(bus.busy), W'(1));
    chk("mthi_busy_ignored", bus.hi, m_hi);
    bus.cancel = 1;
    sb_q.delete();
    @(negedge clk);
    bus.cancel = 0;
    chk("cancel_busy", W'(bus.busy), W'(0));
    repeat (W + 5) @(negedge clk);
    chk("cancel_hi", bus.hi, m_hi);
    chk("cancel_lo", bus.lo, m_lo);
    chk("cancel_idle", W'(bus.busy), W'(0));
    bus.hi_we = 1; bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 0;
    m_hi = 32'hA5A5_A5A5;
    chk("mthi_after", bus.hi, m_hi);

    // Cancel in IDLE suppresses a simultaneous start
    bus.start = 1; bus.cancel = 1;
    @(negedge clk);
    bus.start = 0; bus.cancel = 0;
    chk("cancel_start", W'(bus.busy), W'(0));

    // MTLO with start in the same cycle: write lands, result overwrites
    bus.lo_we = 1; bus.wdata = 32'hCAFE_F00D;
    issue(0, 0, 32'd100, 32'd200);
    bus.lo_we = 0;
    chk("mtlo_with_start", bus.lo, 32'hCAFE_F00D);
    finish_op();

    // Async reset mid-operation
    issue(0, 1, 32'h0012_3456, 32'hFFFF_0001);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    m_hi = '0; m_lo = '0;
    chk("arst_busy", W'(bus.busy), W'(0));
    chk("arst_done", W'(bus.done), W'(0));
    chk("arst_hi", bus.hi, '0);
    chk("arst_lo", bus.lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op(0, 1, 32'd6, 32'd7);
    chk("post_rst_lo", bus.lo, 32'd42);
    chk("post_rst_hi", bus.hi, 32'd0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_expect: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
